// File: rtl/lorenz_euler_source.sv
// Forward-Euler Lorenz integrator in Q8.8. Each requested step is computed on
// one shared multiplier and published as integer and full-precision samples.
module lorenz_euler_source #(
  parameter int INT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_WIDTH = 8,
  parameter int DT_SHIFT  = 7,
  parameter int SIGMA     = 10,
  parameter int RHO       = 28,
  parameter int BETA_Q    = 683,
  parameter int X0        = 256,
  parameter int Y0        = 256,
  parameter int Z0        = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        advance,
  output logic                        busy,
  output logic                        sample_valid,
  output logic signed [OUT_WIDTH-1:0] lorenz_x,
  output logic signed [OUT_WIDTH-1:0] lorenz_y,
  output logic signed [OUT_WIDTH-1:0] lorenz_z,
  output logic signed [INT_WIDTH-1:0] x_q,
  output logic signed [INT_WIDTH-1:0] y_q,
  output logic signed [INT_WIDTH-1:0] z_q,
  output logic [15:0]                 step_count
);

  localparam int PW = 2 * INT_WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL_XY  = 3'd1;
  localparam logic [2:0] S_MUL_XRZ = 3'd2;
  localparam logic [2:0] S_MUL_BZ  = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;

  localparam logic signed [INT_WIDTH-1:0] STATE_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] STATE_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic signed [31:0] SAT_MAX  = 32'(STATE_MAX);
  localparam logic signed [31:0] SAT_MIN  = 32'(STATE_MIN);
  localparam logic signed [31:0] SIGMA_C  = 32'(SIGMA);
  localparam logic signed [INT_WIDTH-1:0] BETA_C = INT_WIDTH'(BETA_Q);
  localparam logic signed [INT_WIDTH:0]   RHO_FX = (INT_WIDTH+1)'(RHO * (2 ** FRAC_BITS));

  logic [2:0] state_q, state_d;
  logic signed [PW-1:0] pxy_q, pxy_d, pxr_q, pxr_d, pbz_q, pbz_d;
  logic signed [INT_WIDTH-1:0] x_d, y_d, z_d;
  logic sample_valid_q, sample_valid_d;
  logic [15:0] step_count_q, step_count_d;

  logic signed [INT_WIDTH:0]   rho_diff;
  logic signed [INT_WIDTH-1:0] rho_op;
  logic signed [INT_WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0]        mul_p, mul_s;
  logic signed [31:0] x_e, y_e, z_e, dx, dy, dz;

  function automatic logic signed [INT_WIDTH-1:0] sat_state(input logic signed [31:0] v);
    if (v > SAT_MAX)      return STATE_MAX;
    else if (v < SAT_MIN) return STATE_MIN;
    else                  return v[INT_WIDTH-1:0];
  endfunction

  // The (rho - z) operand needs one extra bit, then is clamped to the multiplier width.
  always_comb begin
    rho_diff = RHO_FX - $signed({z_q[INT_WIDTH-1], z_q});
    rho_op   = rho_diff[INT_WIDTH-1:0];
    if (rho_diff[INT_WIDTH] != rho_diff[INT_WIDTH-1])
      rho_op = rho_diff[INT_WIDTH] ? STATE_MIN : STATE_MAX;
  end

  always_comb begin
    mul_a = x_q;
    mul_b = y_q;
    case (state_q)
      S_MUL_XRZ: begin mul_a = x_q; mul_b = rho_op; end
      S_MUL_BZ:  begin mul_a = z_q; mul_b = BETA_C; end
      default:   begin mul_a = x_q; mul_b = y_q;    end
    endcase
    mul_p = mul_a * mul_b;
    mul_s = mul_p >>> FRAC_BITS;
  end

  always_comb begin
    x_e = 32'(x_q);
    y_e = 32'(y_q);
    z_e = 32'(z_q);
    dx  = SIGMA_C * (y_e - x_e);
    dy  = 32'(pxr_q) - y_e;
    dz  = 32'(pxy_q) - 32'(pbz_q);
  end

  always_comb begin
    state_d        = state_q;
    pxy_d          = pxy_q;
    pxr_d          = pxr_q;
    pbz_d          = pbz_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    sample_valid_d = 1'b0;
    step_count_d   = step_count_q;
    case (state_q)
      S_IDLE:    if (advance) state_d = S_MUL_XY;
      S_MUL_XY:  begin pxy_d = mul_s; state_d = S_MUL_XRZ; end
      S_MUL_XRZ: begin pxr_d = mul_s; state_d = S_MUL_BZ;  end
      S_MUL_BZ:  begin pbz_d = mul_s; state_d = S_UPDATE;  end
      S_UPDATE: begin
        x_d            = sat_state(x_e + (dx >>> DT_SHIFT));
        y_d            = sat_state(y_e + (dy >>> DT_SHIFT));
        z_d            = sat_state(z_e + (dz >>> DT_SHIFT));
        sample_valid_d = 1'b1;
        step_count_d   = step_count_q + 16'd1;
        state_d        = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pxy_q          <= '0;
      pxr_q          <= '0;
      pbz_q          <= '0;
      x_q            <= INT_WIDTH'(X0);
      y_q            <= INT_WIDTH'(Y0);
      z_q            <= INT_WIDTH'(Z0);
      sample_valid_q <= 1'b0;
      step_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      pxy_q          <= pxy_d;
      pxr_q          <= pxr_d;
      pbz_q          <= pbz_d;
      x_q            <= x_d;
      y_q            <= y_d;
      z_q            <= z_d;
      sample_valid_q <= sample_valid_d;
      step_count_q   <= step_count_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign sample_valid = sample_valid_q;
  assign step_count   = step_count_q;
  assign lorenz_x     = x_q[INT_WIDTH-1:FRAC_BITS];
  assign lorenz_y     = y_q[INT_WIDTH-1:FRAC_BITS];
  assign lorenz_z     = z_q[INT_WIDTH-1:FRAC_BITS];

endmodule

// File: doc/lorenz_euler_source.md
# lorenz_euler_source

Upstream stimulus stage for `lorenz_reservoir`: a fixed-point forward-Euler integrator of the Lorenz system (sigma, rho, beta) that advances one time step per request. Each step runs on a single shared multiplier through a five-state sequence. Each completed step publishes the x, y and z samples as 8-bit signed integers and as full-precision Q8.8 values, with a one-cycle valid strobe. The reservoir consumes `lorenz_x`, `lorenz_y` and `lorenz_z`.

## Interface
- `INT_WIDTH`, 16: state word width, signed Q8.8.
- `FRAC_BITS`, 8: fractional bits of the state.
- `OUT_WIDTH`, 8: published sample width; must equal INT_WIDTH-FRAC_BITS.
- `DT_SHIFT`, 7: time step dt = 2^-DT_SHIFT.
- `SIGMA`, 10: integer sigma.
- `RHO`, 28: integer rho.
- `BETA_Q`, 683: beta in Q8.8 (≈8/3).
- `X0`, `Y0`, `Z0`, 256 each: initial state in Q8.8 (1.0).

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `advance`  in  1  step request; sampled only in IDLE.
- `busy`  out  1  high when the FSM is not in IDLE (combinational from state).
- `sample_valid`  out  1  one-cycle pulse when new samples are published.
- `lorenz_x`, `lorenz_y`, `lorenz_z`  out  OUT_WIDTH signed  integer part of the state.
- `x_q`, `y_q`, `z_q`  out  INT_WIDTH signed  full-precision Q8.8 state.
- `step_count`  out  16  count of completed steps; wraps 65535→0.

## Operation
- **Reset:**
  - x/y/z state = X0/Y0/Z0; `x_q`/`y_q`/`z_q` = 256.
  - `lorenz_*` = 1; `sample_valid` = 0; `step_count` = 0; FSM = IDLE.
  - Takes effect immediately, including mid-step; partial products are discarded.
- **FSM states:** IDLE → MUL_XY → MUL_XRZ → MUL_BZ → UPDATE → IDLE.
  - IDLE: `advance`=1 → MUL_XY; otherwise stay in IDLE.
  - `advance` is ignored in every other state; there is no queuing.
- **Products:** one shared 16×16 signed multiplier, 32-bit result, arithmetic >>> FRAC_BITS, each result registered on leaving its state.
  - MUL_XY: pxy = (x·y) >>> 8.
  - MUL_XRZ: pxr = (x·(RHO<<8 − z)) >>> 8. The subtraction is 17-bit signed; the operand is saturated to 16-bit before the multiply.
  - MUL_BZ: pbz = (z·BETA_Q) >>> 8.
- **UPDATE:** all arithmetic is 32-bit signed.
  - dx = SIGMA·(y − x), using a constant multiply with no shared-multiplier use.
  - dy = pxr − y.
  - dz = pxy − pbz.
  - Each of x, y, z becomes old + (d >>> DT_SHIFT), saturated to [−32768, 32767].
  - All three updates use the pre-step state (simultaneous Euler).
- **Publish:** on the edge leaving UPDATE:
  - state registers, `*_q` and `lorenz_*` = state[15:8] are updated.
  - `sample_valid` is set to 1; `step_count` increments.
  - No output saturation is needed, since −32768>>>8 = −128.
- Outputs hold their values between steps.

## Timing
- `advance` sampled high in IDLE at edge E0:
  - E1: pxy registered.
  - E2: pxr registered.
  - E3: pbz registered.
  - E4: outputs updated, `sample_valid` = 1, FSM back in IDLE.
  - E5: `sample_valid` cleared.
- **Latency:** 4 cycles from request to published data.
- **Back-to-back:** if `advance` is high at E5 it is accepted. With `advance` held high, `sample_valid` pulses every 5 cycles.
- `busy` is high from after E0 through E4, inclusive of the UPDATE cycle.
- Reset asserted at any point returns all outputs to reset values asynchronously. The first edge after deassertion is evaluated in IDLE.

## Test plan
- **Reset values:** hold reset 2 cycles → `x_q`=`y_q`=`z_q`=256, `lorenz_*`=1, `busy`=0, `sample_valid`=0, `step_count`=0.
- **Single step:** pulse `advance` once → 4 edges later `x_q`=256, `y_q`=308, `z_q`=252, `lorenz_x`=1, `lorenz_y`=1, `lorenz_z`=0, `step_count`=1, `sample_valid` high for exactly 1 cycle.
- **Second step:** pulse `advance` again → `x_q`=260, `y_q`=359, `z_q`=249, `step_count`=2.
- **Continuous run:** `advance` held high 50 cycles → exactly 10 `sample_valid` pulses spaced 5 cycles apart; z stays within [0, 50] integer; `busy` low only on accept cycles.
- **Ignored requests:** pulse `advance` in MUL_XRZ and in UPDATE → no extra step; `step_count` increments by one only.
- **Reset mid-operation:** assert reset in MUL_BZ → outputs return to reset values immediately and no `sample_valid` pulse follows. The next `advance` reproduces the single-step values (256/308/252).
